fc_pass_scheduler: RTL and testbench

// Sequences one full pass over an FC layer's weight BRAM. Each pass is either a forward pass
// (MAC plus bias) or a backward pass (weight read-modify-write).

---
 rtl/fc_pass_scheduler.sv | 107 ++++++++++
 tb/tb_fc_pass_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fc_pass_scheduler.sv
// fc_pass_scheduler: sequences one forward or backward pass over an FC layer's weight BRAM.
module fc_pass_scheduler #(
  parameter int ADDR           = 13,
  parameter int BIAS_ADDR      = 4,
  parameter int FAN_IN         = 392,
  parameter int MID_PTR_OFFSET = 196,
  parameter int N_GROUPS       = 16,
  parameter int PIPE_LAT       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 forward,
  input  logic                 valid_i,
  output logic [ADDR-1:0]      head_ptr,
  output logic [ADDR-1:0]      mid_ptr,
  output logic [BIAS_ADDR-1:0] bias_ptr,
  output logic                 has_bias,
  output logic                 acc_clear,
  output logic                 grp_done,
  output logic                 wr_en,
  output logic [ADDR-1:0]      wr_head_ptr,
  output logic [ADDR-1:0]      wr_mid_ptr,
  output logic                 busy,
  output logic                 done
);
  localparam int KW = $clog2(MID_PTR_OFFSET);
  localparam int CW = $clog2(PIPE_LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t               state_q;
  logic [BIAS_ADDR-1:0] g_q;
  logic [KW-1:0]        k_q;
  logic [CW-1:0]        cnt_q;
  logic                 fwd_q;
  logic [PIPE_LAT-1:0]  v_q, l_q;
  logic [ADDR-1:0]      hd_q [PIPE_LAT];
  logic [ADDR-1:0]      md_q [PIPE_LAT];
  logic                 run, fire, k_last, g_last;
  logic [ADDR-1:0]      head, mid;
  always_comb begin
    run    = state_q == RUN;
    fire   = run & valid_i;
    k_last = k_q == KW'(MID_PTR_OFFSET - 1);
    g_last = g_q == BIAS_ADDR'(N_GROUPS - 1);
    head   = ADDR'(g_q) * ADDR'(FAN_IN) + ADDR'(k_q);
    mid    = head + ADDR'(MID_PTR_OFFSET);
  end
  assign head_ptr    = run ? head : '0;
  assign mid_ptr     = run ? mid : '0;
  assign bias_ptr    = run ? g_q : '0;
  assign acc_clear   = run & (k_q == '0);
  assign has_bias    = acc_clear & fwd_q;
  assign grp_done    = v_q[PIPE_LAT-1] & l_q[PIPE_LAT-1];
  assign wr_en       = v_q[PIPE_LAT-1] & ~fwd_q;
  assign wr_head_ptr = wr_en ? hd_q[PIPE_LAT-1] : '0;
  assign wr_mid_ptr  = wr_en ? md_q[PIPE_LAT-1] : '0;
  assign busy        = run | (state_q == DRAIN);
  assign done        = state_q == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      fwd_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          fwd_q   <= forward;
          g_q     <= '0;
          k_q     <= '0;
        end
        RUN: if (valid_i) begin
          k_q <= k_last ? '0 : k_q + KW'(1);
          if (k_last && g_last) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else if (k_last) g_q <= g_q + BIAS_ADDR'(1);
        end
        DRAIN: if (cnt_q == CW'(PIPE_LAT - 1)) state_q <= DONE;
               else cnt_q <= cnt_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  // delay lines advance every cycle so results emerge exactly PIPE_LAT cycles after their beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        hd_q[i] <= '0;
        md_q[i] <= '0;
      end
    end else begin
      v_q <= PIPE_LAT'({v_q, fire});
      l_q <= PIPE_LAT'({l_q, k_last});
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        hd_q[i] <= hd_q[i-1];
        md_q[i] <= md_q[i-1];
      end
      hd_q[0] <= head;
      md_q[0] <= mid;
    end
  end
endmodule

// File: tb/tb_fc_pass_scheduler.sv
// tb_fc_pass_scheduler: directed bench for fc_pass_scheduler pointer sweep, latency and control.
module tb_fc_pass_scheduler;
  localparam int BEATS = 3136, K = 196, L = 4;
  logic        clk = 0, rst = 1, start = 0, forward = 0, valid_i = 0;
  logic [12:0] head_ptr, mid_ptr, wr_head_ptr, wr_mid_ptr;
  logic [3:0]  bias_ptr;
  logic        has_bias, acc_clear, grp_done, wr_en, busy, done;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  fc_pass_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .forward(forward), .valid_i(valid_i),
    .head_ptr(head_ptr), .mid_ptr(mid_ptr), .bias_ptr(bias_ptr), .has_bias(has_bias),
    .acc_clear(acc_clear), .grp_done(grp_done), .wr_en(wr_en), .wr_head_ptr(wr_head_ptr),
    .wr_mid_ptr(wr_mid_ptr), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int hp(input int n);
    return (n / K) * 2 * K + n % K;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_head"}, head_ptr, 0);
    check({tag, "_mid"}, mid_ptr, 0);
    check({tag, "_bias"}, bias_ptr, 0);
    check({tag, "_flags"}, {has_bias, acc_clear, grp_done, wr_en, busy, done}, 0);
    check({tag, "_wrptr"}, wr_head_ptr | wr_mid_ptr, 0);
  endtask
  // mode 0: valid always, 1: toggling, 2: stall on last beat, 3: start re-pulsed at beat 100
  task automatic run_pass(input logic fwd, input int mode, input string tag);
    int n, t_last, err, grp, wr, acc, hb, dn, dn_at, stall, cyc, e, eh;
    bit ev;
    int ev_n[int];
    n = 0; t_last = -1; err = 0; grp = 0; wr = 0; acc = 0; hb = 0;
    dn = 0; dn_at = -1; stall = 0; cyc = 0;
    start = 1; forward = fwd; valid_i = 0;
    step;
    start = 0;
    while (cyc < 15000 && !(t_last >= 0 && cyc > t_last + L + 3)) begin
      ev = ev_n.exists(cyc);
      e  = ev ? ev_n[cyc] : 0;
      if (n < BEATS) begin
        if (head_ptr != hp(n) || mid_ptr != hp(n) + K || bias_ptr != n / K ||
            acc_clear != (n % K == 0) || has_bias != (fwd && n % K == 0)) err++;
      end else if (head_ptr != 0 || mid_ptr != 0 || bias_ptr != 0 || acc_clear || has_bias) err++;
      if (busy != (n < BEATS || cyc <= t_last + L)) err++;
      if (grp_done != (ev && e % K == K - 1)) err++;
      if (wr_en != (ev && !fwd)) err++;
      if (wr_en && (wr_head_ptr != hp(e) || wr_mid_ptr != hp(e) + K)) err++;
      grp += grp_done;
      wr  += wr_en;
      if (done) begin
        dn++;
        dn_at = cyc;
      end
      if (mode == 0 && (n == 0 || n == 196 || n == 3135)) begin
        eh = n == 0 ? 0 : n == 196 ? 392 : 6075;
        check({tag, "_head_pt"}, head_ptr, eh);
        check({tag, "_mid_pt"}, mid_ptr, eh + 196);
        check({tag, "_bias_pt"}, bias_ptr, n == 0 ? 0 : n == 196 ? 1 : 15);
      end
      valid_i = mode == 1 ? (cyc % 2 == 0) : 1'b1;
      if (mode == 2 && n == BEATS - 1 && stall < 10) begin
        valid_i = 0;
        stall++;
        if (stall == 10) begin
          check({tag, "_stall_head"}, head_ptr, 6075);
          check({tag, "_stall_busy"}, busy, 1);
        end
      end
      start = mode == 3 && n == 100;
      if (valid_i && n < BEATS) begin
        acc += acc_clear;
        hb  += has_bias;
        ev_n[cyc + L] = n;
        if (n == BEATS - 1) t_last = cyc;
        n++;
      end
      step;
      cyc++;
    end
    start = 0;
    valid_i = 0;
    check({tag, "_sweep_err"}, err, 0);
    check({tag, "_beats"}, n, BEATS);
    check({tag, "_grp_done"}, grp, 16);
    check({tag, "_wr_en"}, wr, fwd ? 0 : BEATS);
    check({tag, "_acc_clear"}, acc, 16);
    check({tag, "_has_bias"}, hb, fwd ? 16 : 0);
    check({tag, "_done_cnt"}, dn, 1);
    check({tag, "_done_at"}, dn_at, t_last + L + 1);
  endtask
  initial begin
    int grp, wr;
    repeat (3) step;
    check_idle("reset");
    rst = 0;
    step;
    run_pass(1, 0, "fwd");
    run_pass(1, 1, "toggle");
    run_pass(0, 0, "bwd");
    run_pass(1, 3, "restart_ign");
    rst = 1; start = 1;
    step;
    check_idle("rst_start");
    rst = 0; start = 0;
    step;
    check_idle("rst_start_after");
    start = 1; forward = 0;
    step;
    start = 0; valid_i = 1;
    repeat (1000) step;
    check("mid_run_head", head_ptr, hp(1000));
    rst = 1;
    step;
    rst = 0;
    check_idle("mid_reset");
    grp = 0; wr = 0;
    repeat (10) begin
      step;
      grp += grp_done;
      wr  += wr_en;
    end
    check("mid_reset_pulses", grp + wr, 0);
    check("mid_reset_busy", busy, 0);
    valid_i = 0;
    run_pass(0, 2, "stall");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
